// File: rtl/puf_rng_pkg.sv
// -----------------------------------------------------------------------------
// puf_rng_pkg
// Shared definitions for the PUF random-number path: challenge FSM states,
// the default whitening-LFSR seed and the LFSR feedback tap mask, plus a
// single-step helper for the 16-bit Fibonacci LFSR
// (x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0).
// -----------------------------------------------------------------------------
package puf_rng_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam logic [15:0] LFSR_INIT_DEFAULT = 16'hACE1;
   localparam logic [15:0] LFSR_TAP_MASK     = 16'h002D;  // taps at bits 0,2,3,5

   // One LFSR step: feedback enters at the MSB, everything shifts down.
   // The output bit of the step is the pre-step bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {^(s & LFSR_TAP_MASK), s[15:1]};
   endfunction

endpackage

// File: rtl/puf_whiten_lfsr.sv
// -----------------------------------------------------------------------------
// puf_whiten_lfsr
// 16-bit whitening LFSR that delivers STEP output bits per advance. The STEP
// steps are unrolled combinationally so a whole input group is whitened in
// one cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset (state -> LFSR_INIT)
//   advance    move the LFSR forward by STEP steps this cycle
//   seed_load  load seed (zero seed substitutes LFSR_INIT); wins over advance
//   seed       16-bit seed value
//   bits_o     output bits of this cycle; bits_o[STEP-1] is generated first
//   next_o     LFSR state after STEP steps
// -----------------------------------------------------------------------------
module puf_whiten_lfsr
   import puf_rng_pkg::*;
#(
   parameter int unsigned STEP      = 1,
   parameter logic [15:0] LFSR_INIT = LFSR_INIT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            advance,
   input  logic            seed_load,
   input  logic [15:0]     seed,
   output logic [STEP-1:0] bits_o,
   output logic [15:0]     next_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;
   logic [15:0] walk;

   // Walk the register forward STEP times; the oldest input bit (index
   // STEP-1) pairs with the first output bit.
   always_comb begin
      walk   = lfsr_q;
      bits_o = '0;
      for (int i = int'(STEP) - 1; i >= 0; i--) begin
         bits_o[i] = walk[0];
         walk      = lfsr_step(walk);
      end
      next_o = walk;
   end

   // A zero state would lock the LFSR, so a zero seed falls back to LFSR_INIT.
   always_comb begin
      lfsr_d = lfsr_q;
      if (seed_load) begin
         lfsr_d = (seed == 16'h0000) ? LFSR_INIT : seed;
      end else if (advance) begin
         lfsr_d = next_o;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= LFSR_INIT;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/puf_challenge_gen.sv
// -----------------------------------------------------------------------------
// puf_challenge_gen
// Accumulates STEP bits per enabled cycle into an LE-bit challenge word,
// optionally whitened with a 16-bit LFSR stream, and presents the finished
// word with a valid/ready handshake, frozen until accepted.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   en          accept fsr_in this cycle (ignored while holding)
//   mode        0 = raw, 1 = LFSR-whitened; latched on a challenge's first accept
//   fsr_in      STEP input bits, fsr_in[STEP-1] oldest
//   seed_load   load seed into the whitening LFSR
//   seed        16-bit LFSR seed
//   chal        challenge register (new bits enter at the LSB)
//   chal_valid  challenge complete and stable
//   chal_ready  consumer accepts chal while chal_valid is high
//   busy        a challenge is partially filled
//
// LE must be a multiple of STEP, and STEP one of 1, 2, 4, 8.
// -----------------------------------------------------------------------------
module puf_challenge_gen
   import puf_rng_pkg::*;
#(
   parameter int unsigned LE        = 128,
   parameter int unsigned STEP      = 1,
   parameter logic [15:0] LFSR_INIT = LFSR_INIT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            mode,
   input  logic [STEP-1:0] fsr_in,
   input  logic            seed_load,
   input  logic [15:0]     seed,
   output logic [LE-1:0]   chal,
   output logic            chal_valid,
   input  logic            chal_ready,
   output logic            busy
);

   localparam int unsigned      N_GROUPS = LE / STEP;
   localparam int unsigned      CW       = $clog2(N_GROUPS) + 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(N_GROUPS - 1);

   state_e          state_q, state_d;
   logic [LE-1:0]   chal_q, chal_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mode_q, mode_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;

   logic            mode_eff;
   logic            advance;
   logic [STEP-1:0] white_bits;
   logic [15:0]     lfsr_next;
   logic [STEP-1:0] d_bits;

   // The first group of a challenge already uses the mode being latched;
   // later groups use the latched copy, so mid-fill mode changes are ignored.
   assign mode_eff = (cnt_q == '0) ? mode : mode_q;
   assign advance  = (state_q == FILL) && en && mode_eff;
   assign d_bits   = mode_eff ? (fsr_in ^ white_bits) : fsr_in;

   puf_whiten_lfsr #(
      .STEP      (STEP),
      .LFSR_INIT (LFSR_INIT)
   ) u_lfsr (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .seed_load (seed_load),
      .seed      (seed),
      .bits_o    (white_bits),
      .next_o    (lfsr_next)
   );

   always_comb begin
      // NOTE: every signal gets its hold value first, so no branch can leave
      // one unassigned and infer a latch.
      state_d = state_q;
      chal_d  = chal_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      valid_d = valid_q;
      case (state_q)
         FILL: begin
            if (en) begin
               chal_d = {chal_q[LE-STEP-1:0], d_bits};
               mode_d = mode_eff;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  valid_d = 1'b1;
                  state_d = HOLD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            // The handshake cycle never samples fsr_in; filling resumes next cycle.
            if (chal_ready) begin
               valid_d = 1'b0;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
      busy_d = (cnt_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         chal_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         chal_q  <= chal_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign chal       = chal_q;
   assign chal_valid = valid_q;
   assign busy       = busy_q;

   logic unused_next;
   assign unused_next = ^lfsr_next;

endmodule

// File: tb/tb_puf_challenge_gen.sv
// -----------------------------------------------------------------------------
// tb_puf_challenge_gen
// Bench for puf_challenge_gen: an LE=8/STEP=1 instance followed cycle by cycle
// by a bit-level reference model, plus an LE=8/STEP=2 instance driven with
// directed vectors. Literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_puf_challenge_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        en = 1'b0, mode = 1'b0, seed_load = 1'b0, chal_ready = 1'b0;
   logic [0:0]  fsr_in = 1'b0;
   logic [15:0] seed = 16'h0000;
   logic [7:0]  chal;
   logic        chal_valid, busy;

   logic        en2 = 1'b0, chal_ready2 = 1'b0;
   logic [1:0]  fsr2 = 2'b00;
   logic [7:0]  chal2;
   logic        valid2, busy2;

   int total = 0;
   int bad   = 0;

   puf_challenge_gen #(.LE(8), .STEP(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .fsr_in(fsr_in),
      .seed_load(seed_load), .seed(seed), .chal(chal), .chal_valid(chal_valid),
      .chal_ready(chal_ready), .busy(busy)
   );

   puf_challenge_gen #(.LE(8), .STEP(2)) dut2 (
      .clk(clk), .rst(rst), .en(en2), .mode(1'b0), .fsr_in(fsr2),
      .seed_load(1'b0), .seed(16'h0000), .chal(chal2), .chal_valid(valid2),
      .chal_ready(chal_ready2), .busy(busy2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (LE=8, STEP=1) ----------------
   function automatic logic [15:0] m_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   logic [7:0]  m_chal = 8'h00;
   int          m_n    = 0;      // bits collected in the current challenge
   bit          m_hold = 1'b0;
   bit          m_mode = 1'b0;
   logic [15:0] m_lfsr = 16'hACE1;

   always @(posedge clk or posedge rst) begin
      logic b;
      if (rst) begin
         m_chal = 8'h00; m_n = 0; m_hold = 1'b0; m_mode = 1'b0; m_lfsr = 16'hACE1;
      end else begin
         if (m_hold) begin
            if (chal_ready) m_hold = 1'b0;
         end else if (en) begin
            if (m_n == 0) m_mode = mode;
            b = fsr_in[0];
            if (m_mode) begin
               b      = b ^ m_lfsr[0];
               m_lfsr = m_step(m_lfsr);
            end
            m_chal = {m_chal[6:0], b};
            m_n++;
            if (m_n == 8) begin
               m_n    = 0;
               m_hold = 1'b1;
            end
         end
         if (seed_load) m_lfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
      end
   end

   always @(negedge clk) begin
      check("model_chal",  chal, m_chal);
      check("model_valid", chal_valid, m_hold);
      check("model_busy",  busy, m_n != 0);
      check("model_lfsr",  dut1.u_lfsr.lfsr_q, m_lfsr);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Feed pat[from] down to pat[upto] (MSB first) into dut1, one bit per cycle.
   task automatic feed(input logic [7:0] pat, input int from, input int upto);
      for (int i = from; i >= upto; i--) begin
         en        = 1'b1;
         fsr_in[0] = pat[i];
         tick();
      end
      en = 1'b0;
   endtask

   task automatic handshake();
      chal_ready = 1'b1;
      tick();
      chal_ready = 1'b0;
   endtask

   task automatic load_seed(input logic [15:0] s);
      seed      = s;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
   endtask

   logic [1:0] pairs [4] = '{2'b11, 2'b00, 2'b10, 2'b01};

   initial begin
      tick(); tick();
      rst = 1'b0;
      tick();
      check("reset_chal",  chal, 8'h00);
      check("reset_valid", chal_valid, 1'b0);
      check("reset_busy",  busy, 1'b0);
      check("reset_lfsr",  dut1.u_lfsr.lfsr_q, 16'hACE1);

      // Raw fill 1,0,1,1,0,0,1,0
      mode = 1'b0;
      feed(8'hB2, 7, 1);
      check("raw_valid_7", chal_valid, 1'b0);
      check("raw_busy_7",  busy, 1'b1);
      feed(8'hB2, 0, 0);
      check("raw_chal",  chal, 8'hB2);
      check("raw_valid", chal_valid, 1'b1);
      check("raw_busy",  busy, 1'b0);
      handshake();
      check("raw_drop",  chal_valid, 1'b0);
      check("raw_kept",  chal, 8'hB2);

      // Whitened fill with zero input exposes the LFSR output stream
      load_seed(16'h0003);
      mode = 1'b1;
      feed(8'h00, 7, 0);
      check("white3_chal", chal, 8'hC0);
      check("white3_lfsr", dut1.u_lfsr.lfsr_q, 16'h0300);
      handshake();
      load_seed(16'h0001);
      feed(8'h00, 7, 0);
      check("white1_chal", chal, 8'h80);
      check("white1_lfsr", dut1.u_lfsr.lfsr_q, 16'h0100);
      handshake();

      // Seed load colliding with a whitened accept
      feed(8'h5A, 7, 4);
      en = 1'b1; fsr_in[0] = 1'b1; seed = 16'h1234; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      feed(8'h5A, 2, 0);
      check("seedmid_valid", chal_valid, 1'b1);
      handshake();
      mode = 1'b0;

      // STEP=2 instance: groups 11,00,10,01
      for (int i = 0; i < 4; i++) begin
         en2  = 1'b1;
         fsr2 = pairs[i];
         tick();
         if (i == 2) begin
            check("step2_valid_3", valid2, 1'b0);
            check("step2_busy_3",  busy2, 1'b1);
         end
      end
      en2 = 1'b0;
      check("step2_chal",  chal2, 8'hC9);
      check("step2_valid", valid2, 1'b1);
      check("step2_busy",  busy2, 1'b0);
      chal_ready2 = 1'b1;
      tick();
      chal_ready2 = 1'b0;
      check("step2_drop", valid2, 1'b0);

      // HOLD ignores en/fsr_in until the handshake
      feed(8'hA5, 7, 0);
      for (int i = 0; i < 5; i++) begin
         en = 1'b1; fsr_in[0] = i[0];
         tick();
         check("hold_chal",  chal, 8'hA5);
         check("hold_valid", chal_valid, 1'b1);
      end
      en = 1'b1; fsr_in[0] = 1'b1; chal_ready = 1'b1;
      tick();
      chal_ready = 1'b0; en = 1'b0;
      check("hs_valid", chal_valid, 1'b0);
      check("hs_busy",  busy, 1'b0);
      feed(8'h3C, 7, 1);
      check("refill_valid_7", chal_valid, 1'b0);
      feed(8'h3C, 0, 0);
      check("refill_valid", chal_valid, 1'b1);
      check("refill_chal",  chal, 8'h3C);
      handshake();

      // Mode change mid-fill stays raw; ready while not valid is ignored
      mode = 1'b0;
      feed(8'hD3, 7, 5);
      mode = 1'b1; chal_ready = 1'b1;
      feed(8'hD3, 4, 0);
      chal_ready = 1'b0;
      check("modechg_chal",  chal, 8'hD3);
      check("modechg_valid", chal_valid, 1'b1);
      load_seed(16'h0000);
      check("zero_seed_lfsr", dut1.u_lfsr.lfsr_q, 16'hACE1);
      mode = 1'b0;
      handshake();

      // Reset mid-fill discards the partial challenge at once
      feed(8'hFF, 7, 3);
      check("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("rst_chal",  chal, 8'h00);
      check("rst_valid", chal_valid, 1'b0);
      check("rst_busy",  busy, 1'b0);
      tick();
      rst = 1'b0;
      feed(8'h96, 7, 1);
      check("post_rst_valid_7", chal_valid, 1'b0);
      feed(8'h96, 0, 0);
      check("post_rst_valid", chal_valid, 1'b1);
      check("post_rst_chal",  chal, 8'h96);
      handshake();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
